// File: rtl/ledlines_rx_decoder_pkg.sv
// Shared LedLines timing constants, receive FSM state encoding and helpers.
package ledlines_rx_decoder_pkg;

    localparam int LEDLINES_CLK_HZ    = 50_000_000;
    localparam int LEDLINES_T0H_CYC   = 20;
    localparam int LEDLINES_T1H_CYC   = 40;
    localparam int LEDLINES_TBIT_CYC  = 63;
    localparam int LEDLINES_LATCH_CYC = 2500;
    localparam int LEDLINES_PIX_BITS  = 24;

    typedef enum logic [1:0] {
        LRX_WAIT_LATCH = 2'd0,
        LRX_IDLE       = 2'd1,
        LRX_HIGH       = 2'd2,
        LRX_LOW        = 2'd3
    } lrx_state_e;

    // Pixel counter increments but never wraps past all-ones.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/ledlines_rx_decoder_if.sv
// Decoded-pixel output port of the LedLines receiver: valid/ready pixel
// stream plus frame and error status pulses.
interface ledlines_rx_decoder_if #(
    parameter int PIX_BITS = 24
);
    logic [PIX_BITS-1:0] pix_data;
    logic                pix_valid;
    logic                pix_ready;
    logic                frame_end;
    logic [15:0]         pix_count;
    logic                err_timing;
    logic                err_overrun;

    modport master (
        output pix_data,
        output pix_valid,
        input  pix_ready,
        output frame_end,
        output pix_count,
        output err_timing,
        output err_overrun
    );

    modport slave (
        input  pix_data,
        input  pix_valid,
        output pix_ready,
        input  frame_end,
        input  pix_count,
        input  err_timing,
        input  err_overrun
    );
endinterface

// File: rtl/ledlines_rx_decoder_sync_edge.sv
// Multi-flop synchronizer for the asynchronous LED line with single-cycle
// rise/fall indications derived from the synchronized level.
module ledlines_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_async,
    output logic sig_sync,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Shift the raw line through the synchronizer and remember the last synced level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_async};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sig_sync = sync_q[SYNC_STAGES-1];
    assign rise     = sig_sync & ~prev_q;
    assign fall     = ~sig_sync & prev_q;

endmodule

// File: rtl/ledlines_rx_decoder.sv
// LedLines receive decoder: measures high-pulse widths on the synchronized
// LED line, assembles 24-bit pixels MSB first and hands them out on a
// valid/ready port together with frame-end and error pulses.
//
//  state          | meaning
//  ---------------+----------------------------------------------------------
//  LRX_WAIT_LATCH | resync: waiting for a full latch gap, no outputs produced
//  LRX_IDLE       | between frames, waiting for the first rising edge
//  LRX_HIGH       | measuring the width of a high pulse (hcnt)
//  LRX_LOW        | measuring the low time after a bit (lcnt), latch detect
module ledlines_rx_decoder
    import ledlines_rx_decoder_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_HIGH    = 8,
    parameter int BIT_THRESH  = 30,
    parameter int MAX_HIGH    = 60,
    parameter int LATCH_CYC   = LEDLINES_LATCH_CYC,
    parameter int PIX_BITS    = LEDLINES_PIX_BITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  led_sig,
    ledlines_rx_decoder_if.master bus
);

    localparam int CW = $clog2(LATCH_CYC + 1);
    localparam int BW = $clog2(PIX_BITS + 1);

    logic sig_sync;
    logic sig_rise;
    logic sig_fall;

    lrx_state_e          state_q,       state_d;
    logic [CW-1:0]       hcnt_q,        hcnt_d;
    logic [CW-1:0]       lcnt_q,        lcnt_d;
    logic [BW-1:0]       bitcnt_q,      bitcnt_d;
    logic [PIX_BITS-1:0] shreg_q,       shreg_d;
    logic [PIX_BITS-1:0] pix_data_q,    pix_data_d;
    logic                pix_valid_q,   pix_valid_d;
    logic [15:0]         pix_count_q,   pix_count_d;
    logic                frame_end_q,   frame_end_d;
    logic                err_timing_q,  err_timing_d;
    logic                err_overrun_q, err_overrun_d;

    logic                new_bit;
    logic [PIX_BITS-1:0] new_word;

    ledlines_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk       (clk),
        .rst_n     (rst_n),
        .sig_async (led_sig),
        .sig_sync  (sig_sync),
        .rise      (sig_rise),
        .fall      (sig_fall)
    );

    // Bit value of the pulse ending now, and the word it would complete.
    assign new_bit  = (hcnt_q >= CW'(BIT_THRESH));
    assign new_word = {shreg_q[PIX_BITS-2:0], new_bit};

    // State and datapath registers; everything clears on reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= LRX_WAIT_LATCH;
            hcnt_q        <= '0;
            lcnt_q        <= '0;
            bitcnt_q      <= '0;
            shreg_q       <= '0;
            pix_data_q    <= '0;
            pix_valid_q   <= 1'b0;
            pix_count_q   <= '0;
            frame_end_q   <= 1'b0;
            err_timing_q  <= 1'b0;
            err_overrun_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            hcnt_q        <= hcnt_d;
            lcnt_q        <= lcnt_d;
            bitcnt_q      <= bitcnt_d;
            shreg_q       <= shreg_d;
            pix_data_q    <= pix_data_d;
            pix_valid_q   <= pix_valid_d;
            pix_count_q   <= pix_count_d;
            frame_end_q   <= frame_end_d;
            err_timing_q  <= err_timing_d;
            err_overrun_q <= err_overrun_d;
        end
    end

    // Next-state, pulse-width decode, pixel assembly and output handshake.
    always_comb begin
        state_d       = state_q;
        hcnt_d        = hcnt_q;
        lcnt_d        = lcnt_q;
        bitcnt_d      = bitcnt_q;
        shreg_d       = shreg_q;
        pix_data_d    = pix_data_q;
        pix_valid_d   = pix_valid_q;
        pix_count_d   = pix_count_q;
        frame_end_d   = 1'b0;
        err_timing_d  = 1'b0;
        err_overrun_d = 1'b0;

        // A completed handshake empties the output register; a pixel
        // finishing in the same cycle below reloads it.
        if (pix_valid_q && bus.pix_ready) begin
            pix_valid_d = 1'b0;
        end

        case (state_q)
            LRX_WAIT_LATCH: begin
                if (sig_sync) begin
                    lcnt_d = '0;
                end else if (lcnt_q == CW'(LATCH_CYC)) begin
                    state_d = LRX_IDLE;
                end else begin
                    lcnt_d = lcnt_q + CW'(1);
                end
            end

            LRX_IDLE: begin
                if (sig_rise) begin
                    state_d     = LRX_HIGH;
                    hcnt_d      = CW'(1);
                    pix_count_d = 16'd0;
                end
            end

            LRX_HIGH: begin
                if (hcnt_q > CW'(MAX_HIGH)) begin
                    err_timing_d = 1'b1;
                    bitcnt_d     = '0;
                    shreg_d      = '0;
                    lcnt_d       = '0;
                    state_d      = LRX_WAIT_LATCH;
                end else if (sig_fall) begin
                    if (hcnt_q < CW'(MIN_HIGH)) begin
                        err_timing_d = 1'b1;
                        bitcnt_d     = '0;
                        shreg_d      = '0;
                        lcnt_d       = '0;
                        state_d      = LRX_WAIT_LATCH;
                    end else begin
                        state_d = LRX_LOW;
                        lcnt_d  = CW'(1);
                        if (bitcnt_q == BW'(PIX_BITS - 1)) begin
                            bitcnt_d    = '0;
                            shreg_d     = '0;
                            pix_count_d = sat_inc16(pix_count_q);
                            if (!pix_valid_q || bus.pix_ready) begin
                                pix_data_d  = new_word;
                                pix_valid_d = 1'b1;
                            end else begin
                                err_overrun_d = 1'b1;
                            end
                        end else begin
                            bitcnt_d = bitcnt_q + BW'(1);
                            shreg_d  = new_word;
                        end
                    end
                end else if (hcnt_q != {CW{1'b1}}) begin
                    hcnt_d = hcnt_q + CW'(1);
                end
            end

            LRX_LOW: begin
                if (sig_rise) begin
                    state_d = LRX_HIGH;
                    hcnt_d  = CW'(1);
                end else if (lcnt_q == CW'(LATCH_CYC)) begin
                    frame_end_d = 1'b1;
                    if (bitcnt_q != '0) begin
                        err_timing_d = 1'b1;
                        bitcnt_d     = '0;
                        shreg_d      = '0;
                    end
                    state_d = LRX_IDLE;
                end else begin
                    lcnt_d = lcnt_q + CW'(1);
                end
            end

            default: begin
                state_d = LRX_WAIT_LATCH;
                lcnt_d  = '0;
            end
        endcase
    end

    assign bus.pix_data    = pix_data_q;
    assign bus.pix_valid   = pix_valid_q;
    assign bus.pix_count   = pix_count_q;
    assign bus.frame_end   = frame_end_q;
    assign bus.err_timing  = err_timing_q;
    assign bus.err_overrun = err_overrun_q;

endmodule
